// File: rtl/pad_sig_pkg.sv
// Shared constants and edge-classification helper for the pad signal conditioning block.
package pad_sig_pkg;

  localparam int PAD_SIG_W       = 67;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_LEN_DEF    = 4;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } edge_e;

  function automatic edge_e edge_of(input logic prev, input logic nxt);
    if (!prev && nxt)      return EDGE_RISE;
    else if (prev && !nxt) return EDGE_FALL;
    else                   return EDGE_NONE;
  endfunction

endpackage

// File: rtl/pad_sig_filter_bit.sv
// One pad bit: synchroniser chain, consecutive-sample glitch filter, and registered edge pulses.
module pad_sig_filter_bit
  import pad_sig_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int   FILT_LEN    = FILT_LEN_DEF,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  input  logic i_byp,
  output logic o_filt,
  output logic o_rise,
  output logic o_fall,
  output logic o_ev_nxt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_filt;
  logic                   r_rise;
  logic                   r_fall;

  logic             w_s;
  logic             w_filt_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  edge_e            w_edge;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {SYNC_STAGES{RST_VAL}};
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
  end

  // Counter only runs while the synchronised level disagrees with the filtered one.
  always_comb begin
    w_filt_nxt = r_filt;
    w_cnt_nxt  = '0;
    if (i_byp) begin
      w_filt_nxt = w_s;
    end else if (w_s != r_filt) begin
      if (r_cnt == CNT_LAST) w_filt_nxt = w_s;
      else                   w_cnt_nxt  = r_cnt + 1'b1;
    end
  end

  assign w_edge   = edge_of(r_filt, w_filt_nxt);
  assign o_ev_nxt = (w_edge != EDGE_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_filt <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_filt <= w_filt_nxt;
      r_rise <= (w_edge == EDGE_RISE);
      r_fall <= (w_edge == EDGE_FALL);
    end
  end

  assign o_filt = r_filt;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/pad_sig_filter.sv
// Pad input conditioning: per-bit filter instances plus sticky change flags with ack/overflow.
module pad_sig_filter
  import pad_sig_pkg::*;
#(
  parameter int   W           = PAD_SIG_W,
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int   FILT_LEN    = FILT_LEN_DEF,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic         CLK,
  input  logic         RSTB,
  input  logic [W-1:0] SIGI,
  input  logic         BYP,
  output logic [W-1:0] FILT_O,
  output logic [W-1:0] RISE,
  output logic [W-1:0] FALL,
  output logic [W-1:0] CHG_PEND,
  output logic         CHG_VLD,
  input  logic         CHG_ACK,
  output logic         CHG_OVF
);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_param
      $fatal(1, "pad_sig_filter: SYNC_STAGES must be 2..4 and FILT_LEN 1..15");
    end
  endgenerate

  logic [W-1:0] w_ev;
  logic [W-1:0] w_pend_nxt;
  logic         w_ovf_set;

  logic [W-1:0] r_pend;
  logic         r_vld;
  logic         r_ovf;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    pad_sig_filter_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .RST_VAL     (RST_VAL)
    ) u_bit (
      .clk      (CLK),
      .rst_n    (RSTB),
      .i_sig    (SIGI[gi]),
      .i_byp    (BYP),
      .o_filt   (FILT_O[gi]),
      .o_rise   (RISE[gi]),
      .o_fall   (FALL[gi]),
      .o_ev_nxt (w_ev[gi])
    );
  end

  // Edges use next-state so a flag lands in the same cycle as its RISE/FALL pulse;
  // an edge coinciding with the ack survives the clear.
  assign w_pend_nxt = (r_pend & ~(CHG_ACK ? r_pend : '0)) | w_ev;
  assign w_ovf_set  = (|(w_ev & r_pend)) & ~CHG_ACK;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_pend <= '0;
      r_vld  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_vld  <= |w_pend_nxt;
      r_ovf  <= w_ovf_set | (r_ovf & ~CHG_ACK);
    end
  end

  assign CHG_PEND = r_pend;
  assign CHG_VLD  = r_vld;
  assign CHG_OVF  = r_ovf;

endmodule

// File: tb/tb_pad_sig_filter.sv
// Bench for pad_sig_filter: directed scenarios plus random traffic against a window-based model.
module tb_pad_sig_filter;
  import pad_sig_pkg::*;

  localparam int   W     = PAD_SIG_W;
  localparam int   NS    = 2;
  localparam int   FL    = 4;
  localparam logic RV    = 1'b0;
  localparam int   EXP_W = 4 * W + 2;

  // clock / reset
  logic         CLK = 1'b0;
  logic         RSTB = 1'b1;
  logic [W-1:0] SIGI = '0;
  logic         BYP = 1'b0;
  logic         CHG_ACK = 1'b0;
  logic [W-1:0] FILT_O, RISE, FALL, CHG_PEND;
  logic         CHG_VLD, CHG_OVF;

  always #5 CLK = ~CLK;

  pad_sig_filter #(
    .W           (W),
    .SYNC_STAGES (NS),
    .FILT_LEN    (FL),
    .RST_VAL     (RV)
  ) dut (
    .CLK      (CLK),
    .RSTB     (RSTB),
    .SIGI     (SIGI),
    .BYP      (BYP),
    .FILT_O   (FILT_O),
    .RISE     (RISE),
    .FALL     (FALL),
    .CHG_PEND (CHG_PEND),
    .CHG_VLD  (CHG_VLD),
    .CHG_ACK  (CHG_ACK),
    .CHG_OVF  (CHG_OVF)
  );

  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: pad level seen NS edges late; the filtered level flips once the
  // last FL filter-mode samples all disagree with it
  typedef struct packed { logic live; logic [W-1:0] s; } samp_t;
  logic [W-1:0] m_sync_q[$];
  samp_t        m_win_q[$];
  logic [W-1:0] m_filt;
  logic [W-1:0] m_pend;
  logic         m_ovf;

  task automatic model_reset();
    m_sync_q.delete();
    for (int k = 0; k < NS; k++) m_sync_q.push_back({W{RV}});
    m_win_q.delete();
    m_filt = {W{RV}};
    m_pend = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input logic [W-1:0] sigi, input logic byp, input logic ack);
    logic [W-1:0] s_cur, f_new, rise, fall, ev, p_new;
    logic         o_new, flip;
    samp_t        smp;
    s_cur = m_sync_q[NS-1];
    m_sync_q.push_front(sigi);
    void'(m_sync_q.pop_back());
    smp.live = !byp;
    smp.s    = s_cur;
    m_win_q.push_front(smp);
    if (m_win_q.size() > FL) void'(m_win_q.pop_back());
    if (byp) begin
      f_new = s_cur;
    end else begin
      for (int i = 0; i < W; i++) begin
        flip = (m_win_q.size() == FL);
        foreach (m_win_q[k]) if (!m_win_q[k].live || m_win_q[k].s[i] == m_filt[i]) flip = 1'b0;
        f_new[i] = flip ? ~m_filt[i] : m_filt[i];
      end
    end
    rise  = f_new & ~m_filt;
    fall  = ~f_new & m_filt;
    ev    = rise | fall;
    o_new = ((|(ev & m_pend)) && !ack) || (m_ovf && !ack);
    p_new = (ack ? '0 : m_pend) | ev;
    exp_q.push_back({f_new, rise, fall, p_new, |p_new, o_new});
    m_filt = f_new;
    m_pend = p_new;
    m_ovf  = o_new;
  endtask

  // monitor: the DUT presents a new output set after every edge
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("filt_o",   FILT_O,   e[4*W+1 -: W]);
        check("rise",     RISE,     e[3*W+1 -: W]);
        check("fall",     FALL,     e[2*W+1 -: W]);
        check("chg_pend", CHG_PEND, e[W+1 -: W]);
        check("chg_vld",  W'(CHG_VLD), W'(e[1]));
        check("chg_ovf",  W'(CHG_OVF), W'(e[0]));
      end
    end
  end

  // driver tasks: called at negedge+1 with inputs already set for the coming edge
  task automatic step();
    model_edge(SIGI, BYP, CHG_ACK);
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset(input string tag);
    RSTB = 1'b0;
    #1;
    check({tag, "_filt"}, FILT_O, {W{RV}});
    check({tag, "_rise"}, RISE, '0);
    check({tag, "_fall"}, FALL, '0);
    check({tag, "_pend"}, CHG_PEND, '0);
    check({tag, "_vld"},  W'(CHG_VLD), '0);
    check({tag, "_ovf"},  W'(CHG_OVF), '0);
    model_reset();
    @(negedge CLK);
    #1;
    RSTB = 1'b1;
  endtask

  task automatic ack_pulse();
    CHG_ACK = 1'b1;
    step();
    CHG_ACK = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n_rise, n_fall, n_high;
    logic [W-1:0] nx;
    #3;
    do_reset("rst0");

    // 1: clean step latency on bit 5
    SIGI[5] = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      step();
      if (FILT_O[5]) lat = n;
    end
    check("t1_latency", W'(lat), W'(NS + FL));
    check("t1_rise", RISE, W'(1) << 5);
    check("t1_vld", W'(CHG_VLD), W'(1));
    repeat (2) step();
    ack_pulse();

    // 2: 3-cycle glitch suppressed, 4-cycle pulse passes
    SIGI[0] = 1'b1;
    repeat (3) step();
    SIGI[0] = 1'b0;
    repeat (10) step();
    check("t2_glitch_filt", FILT_O & W'(1), '0);
    check("t2_glitch_pend", CHG_PEND, '0);
    SIGI[0] = 1'b1;
    repeat (4) step();
    SIGI[0] = 1'b0;
    n_rise = 0;
    for (int n = 0; n < 12; n++) begin
      if (RISE[0]) n_rise++;
      step();
    end
    check("t2_pulse_rise", W'(n_rise), W'(1));
    ack_pulse();
    repeat (2) step();

    // 3: ack racing a new edge
    SIGI[0] = 1'b1;
    repeat (NS + FL + 1) step();
    check("t3_pend0", CHG_PEND, W'(1));
    SIGI[7] = 1'b1;
    repeat (NS + FL - 1) step();
    CHG_ACK = 1'b1;
    step();
    CHG_ACK = 1'b0;
    check("t3_pend7", CHG_PEND, W'(1) << 7);
    check("t3_vld", W'(CHG_VLD), W'(1));
    check("t3_ovf", W'(CHG_OVF), '0);
    ack_pulse();

    // 4: overflow
    SIGI[3] = 1'b1;
    repeat (NS + FL) step();
    repeat (10) step();
    SIGI[3] = 1'b0;
    repeat (NS + FL + 1) step();
    check("t4_ovf_set", W'(CHG_OVF), W'(1));
    ack_pulse();
    check("t4_ovf_clr", W'(CHG_OVF), '0);
    check("t4_pend_clr", CHG_PEND, '0);

    // 5: bypass passes a single-cycle pulse
    BYP = 1'b1;
    SIGI[66] = 1'b1;
    step();
    SIGI[66] = 1'b0;
    n_rise = 0; n_fall = 0; n_high = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (RISE[66]) n_rise++;
      if (FALL[66]) n_fall++;
      if (FILT_O[66]) n_high++;
    end
    check("t5_rise", W'(n_rise), W'(1));
    check("t5_fall", W'(n_fall), W'(1));
    check("t5_high", W'(n_high), W'(1));
    BYP = 1'b0;
    ack_pulse();

    // 6: reset mid-count with all pads high
    SIGI = '1;
    repeat (NS + 2) step();
    do_reset("t6_rst");
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      step();
      if (FILT_O == '1) lat = n;
    end
    check("t6_latency", W'(lat), W'(NS + FL));
    check("t6_rise_all", RISE, '1);
    ack_pulse();

    // random traffic
    for (int c = 0; c < 700; c++) begin
      nx = SIGI;
      for (int i = 0; i < W; i++) if ($urandom_range(0, 11) == 0) nx[i] = ~nx[i];
      SIGI = nx;
      if ($urandom_range(0, 63) == 0) BYP = ~BYP;
      CHG_ACK = ($urandom_range(0, 9) == 0);
      if (c == 350) do_reset("rand_rst");
      else step();
    end
    CHG_ACK = 1'b0;
    BYP = 1'b0;
    @(posedge CLK);
    #3;
    check("queue_drained", W'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
